// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// ALUOp codes and datapath mux selects.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mcu_retire_counter.sv
// Free-running 32-bit retired-instruction counter; wraps naturally at 2^32.
module mcu_retire_counter (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_r <= 32'd0;
        end else if (en) begin
            count_r <= count_r + 32'd1;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle MIPS datapath.
// Define MCU_BNE_EN to decode BNE (opcode 000101) through the BRANCH state.
module multicycle_control_unit
    import mcu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_ne,
    output logic [1:0]  pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [31:0] retired
);

    state_t state_r;
    state_t next_state_s;
    logic   illegal_r;
    logic   set_illegal_s;
    logic   retire_en_s;

    // State and sticky illegal flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            illegal_r <= illegal_r | set_illegal_s;
        end
    end

    // Next-state and output decode; everything is held low while reset is asserted.
    always_comb begin
        next_state_s  = S_FETCH;
        set_illegal_s = 1'b0;
        retire_en_s   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = 3'b000;
        if (reset) begin
            case (state_r)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALUOP_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) begin
                        next_state_s = S_DECODE;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    alu_op    = ALUOP_ADD;
                    case (opcode)
                        OP_RTYPE:       next_state_s = S_R_EXEC;
                        OP_LW, OP_SW:   next_state_s = S_MEM_ADDR;
                        OP_BEQ:         next_state_s = S_BRANCH;
`ifdef MCU_BNE_EN
                        OP_BNE:         next_state_s = S_BRANCH;
`endif
                        OP_J:           next_state_s = S_JUMP;
                        OP_ADDI,
                        OP_ORI:         next_state_s = S_I_EXEC;
                        default: begin
                            next_state_s  = S_ILLEGAL;
                            set_illegal_s = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_ADD;
                    // The IR is stable, so lw/sw is re-sampled here rather than carried.
                    if (opcode == OP_SW) begin
                        next_state_s = S_MEM_WRITE;
                    end else begin
                        next_state_s = S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        next_state_s = S_MEM_WB;
                    end else begin
                        next_state_s = S_MEM_READ;
                    end
                end
                S_MEM_WB: begin
                    reg_write   = 1'b1;
                    mem_to_reg  = 1'b1;
                    retire_en_s = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        next_state_s = S_FETCH;
                        retire_en_s  = 1'b1;
                    end else begin
                        next_state_s = S_MEM_WRITE;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_RT;
                    alu_op       = ALUOP_RTYPE;
                    next_state_s = S_R_WB;
                end
                S_R_WB: begin
                    reg_write   = 1'b1;
                    reg_dst     = 1'b1;
                    retire_en_s = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRCB_RT;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    retire_en_s   = 1'b1;
`ifdef MCU_BNE_EN
                    branch_ne     = (opcode == OP_BNE);
`else
                    branch_ne     = 1'b0;
`endif
                end
                S_JUMP: begin
                    pc_write    = 1'b1;
                    pc_source   = PCSRC_JUMP;
                    retire_en_s = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (opcode == OP_ORI) begin
                        alu_op = ALUOP_OR;
                    end else begin
                        alu_op = ALUOP_ADD;
                    end
                    next_state_s = S_I_WB;
                end
                S_I_WB: begin
                    reg_write   = 1'b1;
                    retire_en_s = 1'b1;
                end
                S_ILLEGAL: begin
                    next_state_s = S_FETCH;
                end
                default: begin
                    next_state_s = S_FETCH;
                end
            endcase
        end else begin
            next_state_s = S_FETCH;
        end
    end

    mcu_retire_counter u_retire (
        .clk     (clk),
        .clear_n (reset),
        .en      (retire_en_s),
        .count   (retired)
    );

    assign state      = state_r;
    assign illegal_op = illegal_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected state/stimulus pairs are
// queued per scenario and popped one per clock.
module tb_multicycle_control_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] retired;

    typedef struct {
        logic       mr;
        logic [5:0] op;
        logic [3:0] st;
    } item_t;

    item_t       exp_q[$];
    int          total;
    int          passed;
    logic [31:0] exp_ret;

    multicycle_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .state         (state),
        .illegal_op    (illegal_op),
        .retired       (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input logic mr, input logic [5:0] op, input logic [3:0] st);
        item_t it;
        it.mr = mr;
        it.op = op;
        it.st = st;
        exp_q.push_back(it);
    endtask

    task automatic test_reset();
        reset = 1'b0; opcode = 6'b000000; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        total++; if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
        total++; if (retired !== 32'd0) $display("FAIL reset_retired: got %0h expected 0", retired); else passed++;
        total++; if (illegal_op !== 1'b0) $display("FAIL reset_illegal: got %0b expected 0", illegal_op); else passed++;
        total++; if ({mem_read, ir_write, pc_write, alu_src_b, alu_op} !== 8'd0)
            $display("FAIL reset_outputs: got %0h expected 0", {mem_read, ir_write, pc_write, alu_src_b, alu_op}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_rtype();
        item_t it;
        reset = 1'b1;
        push(1'b1, 6'b000000, 4'd0); push(1'b1, 6'b000000, 4'd1); push(1'b1, 6'b000000, 4'd6);
        push(1'b1, 6'b000000, 4'd7); push(1'b1, 6'b000000, 4'd0);
        exp_ret = exp_ret + 32'd1;
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            it = exp_q.pop_front(); mem_ready = it.mr; opcode = it.op; #1;
            total++; if (state !== it.st) $display("FAIL rtype_state: step %0d got %0d expected %0d", i, state, it.st); else passed++;
            if (i == 0) begin
                total++; if ({mem_read, ir_write, pc_write} !== 3'b111) $display("FAIL rtype_fetch: got %b expected 111", {mem_read, ir_write, pc_write}); else passed++;
            end
            if (it.st == 4'd6) begin
                total++; if (alu_op !== 3'b111) $display("FAIL rtype_aluop: got %b expected 111", alu_op); else passed++;
            end
            if (it.st == 4'd7) begin
                total++; if ({reg_write, reg_dst} !== 2'b11) $display("FAIL rtype_wb: got %b expected 11", {reg_write, reg_dst}); else passed++;
            end
        end
        total++; if (retired !== exp_ret) $display("FAIL rtype_retired: got %0d expected %0d", retired, exp_ret); else passed++;
    endtask

    task automatic test_lw_stall();
        item_t it;
        int    cycles;
        push(1'b1, 6'b100011, 4'd0); push(1'b1, 6'b100011, 4'd1); push(1'b1, 6'b100011, 4'd2);
        push(1'b0, 6'b100011, 4'd3); push(1'b0, 6'b100011, 4'd3); push(1'b1, 6'b100011, 4'd3);
        push(1'b1, 6'b100011, 4'd4); push(1'b1, 6'b100011, 4'd0);
        exp_ret = exp_ret + 32'd1;
        cycles = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            it = exp_q.pop_front(); mem_ready = it.mr; opcode = it.op; #1;
            if (exp_q.size() > 0) cycles++;
            total++; if (state !== it.st) $display("FAIL lw_state: step %0d got %0d expected %0d", i, state, it.st); else passed++;
            if (it.st == 4'd3) begin
                total++; if ({mem_read, i_or_d, reg_write} !== 3'b110) $display("FAIL lw_memread: got %b expected 110", {mem_read, i_or_d, reg_write}); else passed++;
            end
            if (it.st == 4'd4) begin
                total++; if ({mem_to_reg, reg_write, reg_dst} !== 3'b110) $display("FAIL lw_wb: got %b expected 110", {mem_to_reg, reg_write, reg_dst}); else passed++;
                total++; if (retired !== exp_ret - 32'd1) $display("FAIL lw_retired_early: got %0d expected %0d", retired, exp_ret - 32'd1); else passed++;
            end
        end
        total++; if (cycles != 7) $display("FAIL lw_cycles: got %0d expected 7", cycles); else passed++;
        total++; if (retired !== exp_ret) $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret); else passed++;
    endtask

    task automatic test_back_to_back();
        item_t it;
        push(1'b0, 6'b101011, 4'd0); push(1'b0, 6'b101011, 4'd0); push(1'b1, 6'b101011, 4'd0);
        push(1'b1, 6'b101011, 4'd1); push(1'b1, 6'b101011, 4'd2); push(1'b1, 6'b101011, 4'd5);
        push(1'b1, 6'b001000, 4'd0); push(1'b1, 6'b001000, 4'd1); push(1'b1, 6'b001000, 4'd10);
        push(1'b1, 6'b001000, 4'd11);
        push(1'b1, 6'b001101, 4'd0); push(1'b1, 6'b001101, 4'd1); push(1'b1, 6'b001101, 4'd10);
        push(1'b1, 6'b001101, 4'd11); push(1'b1, 6'b001101, 4'd0);
        exp_ret = exp_ret + 32'd3;
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            it = exp_q.pop_front(); mem_ready = it.mr; opcode = it.op; #1;
            total++; if (state !== it.st) $display("FAIL b2b_state: step %0d got %0d expected %0d", i, state, it.st); else passed++;
            if (it.st == 4'd0) begin
                total++; if ({ir_write, pc_write} !== {it.mr, it.mr}) $display("FAIL b2b_fetch_gate: got %b expected %b", {ir_write, pc_write}, {it.mr, it.mr}); else passed++;
            end
            if (it.st == 4'd5) begin
                total++; if ({mem_write, i_or_d, mem_read} !== 3'b110) $display("FAIL b2b_memwrite: got %b expected 110", {mem_write, i_or_d, mem_read}); else passed++;
            end
            if (it.st == 4'd10) begin
                total++; if (alu_op !== ((it.op == 6'b001101) ? 3'b101 : 3'b100)) $display("FAIL b2b_iexec_aluop: got %b op %b", alu_op, it.op); else passed++;
                total++; if ({alu_src_a, alu_src_b} !== 3'b110) $display("FAIL b2b_iexec_src: got %b expected 110", {alu_src_a, alu_src_b}); else passed++;
            end
            if (it.st == 4'd11) begin
                total++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) $display("FAIL b2b_iwb: got %b expected 100", {reg_write, reg_dst, mem_to_reg}); else passed++;
            end
        end
        total++; if (retired !== exp_ret) $display("FAIL b2b_retired: got %0d expected %0d", retired, exp_ret); else passed++;
    endtask

    task automatic test_branch();
        item_t      it;
        logic [3:0] bne_st;
`ifdef MCU_BNE_EN
        bne_st = 4'd8;
        exp_ret = exp_ret + 32'd2;
`else
        bne_st = 4'd12;
        exp_ret = exp_ret + 32'd1;
`endif
        push(1'b1, 6'b000100, 4'd0); push(1'b1, 6'b000100, 4'd1); push(1'b1, 6'b000100, 4'd8);
        push(1'b1, 6'b000101, 4'd0); push(1'b1, 6'b000101, 4'd1); push(1'b1, 6'b000101, bne_st);
        push(1'b1, 6'b000101, 4'd0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            it = exp_q.pop_front(); mem_ready = it.mr; opcode = it.op; #1;
            total++; if (state !== it.st) $display("FAIL branch_state: step %0d got %0d expected %0d", i, state, it.st); else passed++;
            if (it.st == 4'd8) begin
                total++; if ({alu_op, pc_write_cond, pc_source, pc_write} !== 7'b1101010) $display("FAIL branch_ctl: got %b expected 1101010", {alu_op, pc_write_cond, pc_source, pc_write}); else passed++;
                total++; if (branch_ne !== (it.op == 6'b000101)) $display("FAIL branch_ne: got %b op %b", branch_ne, it.op); else passed++;
            end
        end
        total++; if (retired !== exp_ret) $display("FAIL branch_retired: got %0d expected %0d", retired, exp_ret); else passed++;
    endtask

    task automatic test_illegal();
        item_t it;
        push(1'b1, 6'b111111, 4'd0); push(1'b1, 6'b111111, 4'd1); push(1'b1, 6'b111111, 4'd12);
        push(1'b1, 6'b001000, 4'd0); push(1'b1, 6'b001000, 4'd1); push(1'b1, 6'b001000, 4'd10);
        push(1'b1, 6'b001000, 4'd11); push(1'b1, 6'b001000, 4'd0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            it = exp_q.pop_front(); mem_ready = it.mr; opcode = it.op; #1;
            total++; if (state !== it.st) $display("FAIL illegal_state: step %0d got %0d expected %0d", i, state, it.st); else passed++;
            if (i >= 2) begin
                total++; if (illegal_op !== 1'b1) $display("FAIL illegal_sticky: step %0d got %b expected 1", i, illegal_op); else passed++;
            end
            if (it.st == 4'd12) begin
                total++; if ({mem_read, mem_write, reg_write, pc_write, ir_write} !== 5'b0) $display("FAIL illegal_strobes: got %b expected 00000", {mem_read, mem_write, reg_write, pc_write, ir_write}); else passed++;
            end
            if (i == 3) begin
                total++; if (retired !== exp_ret) $display("FAIL illegal_retired: got %0d expected %0d", retired, exp_ret); else passed++;
            end
        end
        exp_ret = exp_ret + 32'd1;
        total++; if (retired !== exp_ret) $display("FAIL illegal_addi_retired: got %0d expected %0d", retired, exp_ret); else passed++;
    endtask

    task automatic test_reset_mid();
        item_t it;
        push(1'b1, 6'b101011, 4'd0); push(1'b1, 6'b101011, 4'd1); push(1'b1, 6'b101011, 4'd2);
        push(1'b1, 6'b101011, 4'd5);
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            it = exp_q.pop_front(); mem_ready = it.mr; opcode = it.op; #1;
            total++; if (state !== it.st) $display("FAIL rmid_state: step %0d got %0d expected %0d", i, state, it.st); else passed++;
        end
        total++; if (mem_write !== 1'b1) $display("FAIL rmid_pre_write: got %b expected 1", mem_write); else passed++;
        reset = 1'b0; #1;
        total++; if ({mem_write, i_or_d} !== 2'b00) $display("FAIL rmid_write_abort: got %b expected 00", {mem_write, i_or_d}); else passed++;
        total++; if (retired !== 32'd0) $display("FAIL rmid_retired: got %0d expected 0", retired); else passed++;
        total++; if ({state, illegal_op} !== 5'd0) $display("FAIL rmid_state_clr: got %0h expected 0", {state, illegal_op}); else passed++;
        @(posedge clk); #1;
        total++; if ({mem_write, reg_write, pc_write, retired} !== 35'd0) $display("FAIL rmid_hold: got %0h expected 0", {mem_write, reg_write, pc_write, retired}); else passed++;
        @(negedge clk);
        reset = 1'b1; exp_ret = 32'd0; #1;
        total++; if ({state, mem_read} !== 5'b00001) $display("FAIL rmid_release: got %b expected 00001", {state, mem_read}); else passed++;
    endtask

    task automatic test_wrap();
        item_t it;
        push(1'b1, 6'b000010, 4'd0); push(1'b1, 6'b000010, 4'd1); push(1'b1, 6'b000010, 4'd9);
        push(1'b1, 6'b000010, 4'd0);
        exp_ret = 32'd0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            if (i > 0) @(negedge clk);
            it = exp_q.pop_front(); mem_ready = it.mr; opcode = it.op; #1;
            total++; if (state !== it.st) $display("FAIL wrap_state: step %0d got %0d expected %0d", i, state, it.st); else passed++;
            if (it.st == 4'd1) begin
                force dut.u_retire.count_r = 32'hFFFF_FFFF;
                #1;
                release dut.u_retire.count_r;
            end
            if (it.st == 4'd9) begin
                total++; if ({pc_write, pc_source, pc_write_cond} !== 4'b1100) $display("FAIL wrap_jump: got %b expected 1100", {pc_write, pc_source, pc_write_cond}); else passed++;
                total++; if (retired !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %0h expected ffffffff", retired); else passed++;
            end
        end
        total++; if (retired !== exp_ret) $display("FAIL wrap_retired: got %0h expected %0h", retired, exp_ret); else passed++;
    endtask

    initial begin
        total = 0; passed = 0; exp_ret = 32'd0;
        reset = 1'b0; opcode = 6'b000000; mem_ready = 1'b1;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_branch();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style sequencer for the multicycle MIPS datapath. It decodes the opcode held in the instruction register and steps the datapath through fetch, decode, execute, memory and writeback. It drives every mux select, write enable and the 3-bit ALUOp consumed by the ALU control decoder. It stalls on a memory ready handshake and counts retired instructions.

## Interface
- No parameters. Encodings are fixed in the shared package.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified in the datapath by branch outcome.
- branch_ne  out  1  invert the zero qualifier (BNE).
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback data: 0 ALUOut, 1 MDR.
- reg_dst  out  1  destination register: 0 rt, 1 rd.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A input: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B input: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  out  3  111 R-type (decode funct), 100 ADD, 101 OR, 110 SUB.
- state  out  4  current state, for debug.
- illegal_op  out  1  sticky flag: an unsupported opcode was decoded.
- retired  out  32  count of completed instructions.

## Operation
- States and codes:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5.
  - R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, ILLEGAL 12.
  - Codes 13–15 go to FETCH.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut).
  - Next state by opcode:
    - 000000 → R_EXEC
    - 100011 (lw), 101011 (sw) → MEM_ADDR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - 001000 (addi), 001101 (ori) → I_EXEC
    - any other opcode → ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD for addi or OR for ori. Opcode is re-sampled here; the IR is stable.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
- ILLEGAL: no strobes. Sets illegal_op. Next state FETCH. Does not increment retired.
- Next state after MEM_WB, R_WB, I_WB, BRANCH and JUMP is FETCH. Each of these transitions increments retired; so does leaving MEM_WRITE.
- retired wraps from 0xFFFF_FFFF to 0.
- Any output not listed for a state is 0.

## Timing
- state, illegal_op and retired are registered. All other outputs decode combinationally from state; the FETCH and memory strobes are also gated by mem_ready as stated above.
- Latency with mem_ready tied high:
  - lw: 5 cycles.
  - sw, R-type, addi, ori: 4 cycles.
  - beq, j: 3 cycles.
  - illegal opcode: 3 cycles.
- Each cycle with mem_ready low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready outside those three states is ignored.
- While reset is low:
  - state=FETCH, retired=0, illegal_op=0.
  - All other outputs are forced to 0.
- Reset asserted mid-instruction aborts it with no writes in any following cycle. The first FETCH comes on the first edge after release.

## Configuration
- MCU_BNE_EN defined:
  - Opcode 000101 decodes to BRANCH.
  - In BRANCH, branch_ne=1 for that opcode.
  - alu_op=SUB in both beq and bne.
- MCU_BNE_EN undefined: opcode 000101 goes to ILLEGAL and branch_ne is tied to 0.

## Structure
- Package mcu_pkg holds:
  - state encoding constants;
  - opcode constants;
  - ALUOp constants 3'b111/100/101/110;
  - alu_src_b and pc_source select constants.
- One sub-module, mcu_retire_counter: 32-bit counter with increment enable and asynchronous active-low clear.
- FSM next-state and output decode stay in the top module.

## Test plan
- Reset release with opcode=000000 and mem_ready=1:
  - state sequence 0,1,6,7,0;
  - alu_op=111 in state 6, reg_write=1 with reg_dst=1 in state 7;
  - retired=1.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ: states 0,1,2,3,3,3,4,0; mem_to_reg=1 in state 4; 7 cycles total.
- beq (000100):
  - alu_op=110, pc_write_cond=1 and pc_source=01 in state 8;
  - with MCU_BNE_EN, opcode 000101 gives branch_ne=1;
  - without it, 000101 reaches state 12.
- Opcode 111111: state 12 with illegal_op=1 sticky across later valid instructions; retired unchanged.
- Reset dropped during MEM_WRITE with mem_ready=1 on the same edge: mem_write=0 and retired=0 immediately; after release, state=0.
- Preload retired=0xFFFF_FFFF via a forced counter value, execute j (000010): states 0,1,9; pc_write=1 with pc_source=10; retired wraps to 0.
